// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_pkg                                                           |
// | Shared state encoding and default widths for the pipeline buffer.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pipe_pkg;

  localparam int c_DEF_DATA_W    = 16;
  localparam int c_DEF_CTRL_W    = 3;
  localparam int c_DEF_NUM_WORDS = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_buffer                                                        |
// | Two-entry skid buffer with registered in_ready and flush.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pipe_buffer
  import pipe_pkg::*;
#(
  parameter int DATA_W    = c_DEF_DATA_W,
  parameter int NUM_WORDS = c_DEF_NUM_WORDS,
  parameter int CTRL_W    = c_DEF_CTRL_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W*NUM_WORDS-1:0]   in_data,
  input  logic [CTRL_W-1:0]             in_ctrl,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W*NUM_WORDS-1:0]   out_data,
  output logic [CTRL_W-1:0]             out_ctrl,
  input  logic                          flush
);

  localparam int c_PAYLOAD_W = DATA_W * NUM_WORDS;

  pipe_state_t              r_state;
  logic [c_PAYLOAD_W-1:0]   r_mainData;
  logic [c_PAYLOAD_W-1:0]   r_skidData;
  logic [CTRL_W-1:0]        r_mainCtrl;
  logic [CTRL_W-1:0]        r_skidCtrl;
  logic                     r_mainValid;
  logic                     r_skidValid;
  logic                     r_inReady;

  logic w_accept;
  logic w_take;

  assign w_accept = in_valid & r_inReady;
  assign w_take   = r_mainValid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_mainData  <= '0;
      r_skidData  <= '0;
      r_mainCtrl  <= '0;
      r_skidCtrl  <= '0;
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
      r_inReady   <= 1'b1;
    end else if (flush) begin
      // Data registers keep their contents; only the valid bits are dropped.
      r_state     <= EMPTY;
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
      r_inReady   <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_mainData  <= in_data;
            r_mainCtrl  <= in_ctrl;
            r_mainValid <= 1'b1;
            r_state     <= ONE;
          end
        end
        ONE: begin
          if (w_accept && w_take) begin
            r_mainData <= in_data;
            r_mainCtrl <= in_ctrl;
          end else if (w_accept) begin
            r_skidData  <= in_data;
            r_skidCtrl  <= in_ctrl;
            r_skidValid <= 1'b1;
            r_inReady   <= 1'b0;
            r_state     <= TWO;
          end else if (w_take) begin
            r_mainValid <= 1'b0;
            r_state     <= EMPTY;
          end
        end
        TWO: begin
          if (w_take) begin
            r_mainData  <= r_skidData;
            r_mainCtrl  <= r_skidCtrl;
            r_skidValid <= 1'b0;
            r_inReady   <= 1'b1;
            r_state     <= ONE;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_mainValid <= 1'b0;
          r_skidValid <= 1'b0;
          r_inReady   <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_mainValid;
  assign out_data  = r_mainData;
  // A bubble must never present a live write enable downstream.
  assign out_ctrl  = r_mainValid ? r_mainCtrl : '0;

endmodule : pipe_buffer
`default_nettype wire

// File: tb/tb_pipe_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_buffer                                                     |
// | Directed self-checking bench for pipe_buffer (default + wide).     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_pipe_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        flush;

  logic        in_ready;
  logic [63:0] in_data;
  logic [2:0]  in_ctrl;
  logic        out_valid;
  logic [63:0] out_data;
  logic [2:0]  out_ctrl;

  logic        p_in_ready;
  logic [63:0] p_in_data;
  logic [4:0]  p_in_ctrl;
  logic        p_out_valid;
  logic [63:0] p_out_data;
  logic [4:0]  p_out_ctrl;

  int checks = 0;
  int errors = 0;

  pipe_buffer u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .flush    (flush)
  );

  pipe_buffer #(
    .DATA_W   (32),
    .NUM_WORDS(2),
    .CTRL_W   (5)
  ) u_dutWide (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (p_in_ready),
    .in_data  (p_in_data),
    .in_ctrl  (p_in_ctrl),
    .out_valid(p_out_valid),
    .out_ready(out_ready),
    .out_data (p_out_data),
    .out_ctrl (p_out_ctrl),
    .flush    (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input logic [15:0] w);
    return {16'h3000 + w, 16'h2000 + w, 16'h1000 + w, w};
  endfunction

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 3'b111;
    in_data   = mk(16'h00FF);
    p_in_ctrl = 5'h1F;
    p_in_data = 64'h0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Asynchronous reset, observed before the first clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_data",  out_data,       64'd0);
    chk("rst_wide_valid", 64'(p_out_valid), 64'd0);

    @(posedge clk);
    #2 rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    // Streaming, one beat per cycle.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid  = 1'b1;
      in_data   = mk(16'(i));
      in_ctrl   = 3'(i);
      p_in_data = {32'hDEADBEEF, 32'(i)};
      p_in_ctrl = 5'(i) + 5'h10;
      tick();
      chk("stream_valid",      64'(out_valid),   64'd1);
      chk("stream_data",       out_data,         mk(16'(i)));
      chk("stream_ctrl",       64'(out_ctrl),    64'(i % 8));
      chk("stream_in_ready",   64'(in_ready),    64'd1);
      chk("wide_stream_valid", 64'(p_out_valid), 64'd1);
      chk("wide_stream_data",  p_out_data,       {32'hDEADBEEF, 32'(i)});
      chk("wide_stream_ctrl",  64'(p_out_ctrl),  64'(i + 16));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", 64'(out_valid),   64'd0);
    chk("wide_drain_valid",   64'(p_out_valid), 64'd0);

    // Backpressure into the skid register.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk(16'h00A1);
    in_ctrl   = 3'b001;
    tick();
    chk("bp_a1_valid",    64'(out_valid), 64'd1);
    chk("bp_a1_data",     out_data,       mk(16'h00A1));
    chk("bp_a1_in_ready", 64'(in_ready),  64'd1);
    in_data = mk(16'h00A2);
    in_ctrl = 3'b010;
    tick();
    chk("bp_two_in_ready", 64'(in_ready), 64'd0);
    chk("bp_two_data",     out_data,      mk(16'h00A1));
    in_data = mk(16'h00A9);
    in_ctrl = 3'b011;
    tick();
    chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_data",     out_data,      mk(16'h00A1));
    chk("bp_hold_ctrl",     64'(out_ctrl), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_a2_valid",    64'(out_valid), 64'd1);
    chk("bp_a2_data",     out_data,       mk(16'h00A2));
    chk("bp_a2_ctrl",     64'(out_ctrl),  64'd2);
    chk("bp_a2_in_ready", 64'(in_ready),  64'd1);
    tick();
    chk("bp_done_valid", 64'(out_valid), 64'd0);

    // Bubble must show zero ctrl but keep the last payload.
    in_valid = 1'b1;
    in_data  = mk(16'h00C5);
    in_ctrl  = 3'b101;
    tick();
    chk("bub_beat_ctrl", 64'(out_ctrl), 64'd5);
    in_valid = 1'b0;
    tick();
    chk("bub_valid", 64'(out_valid), 64'd0);
    chk("bub_ctrl",  64'(out_ctrl),  64'd0);
    chk("bub_data",  out_data,       mk(16'h00C5));

    // Flush from TWO with an incoming beat.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk(16'h0B01);
    tick();
    in_data = mk(16'h0B02);
    tick();
    chk("fl_two_in_ready", 64'(in_ready), 64'd0);
    flush   = 1'b1;
    in_data = mk(16'h0B03);
    tick();
    chk("fl_valid",    64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready),  64'd1);
    chk("fl_ctrl",     64'(out_ctrl),  64'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("fl_after_valid", 64'(out_valid), 64'd0);

    // Flush from ONE discards a same-cycle accept.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk(16'h00D1);
    tick();
    chk("fl1_loaded", 64'(out_valid), 64'd1);
    flush   = 1'b1;
    in_data = mk(16'h00D2);
    tick();
    chk("fl1_valid", 64'(out_valid), 64'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("fl1_after_valid", 64'(out_valid), 64'd0);
    chk("fl1_in_ready",    64'(in_ready),  64'd1);

    // Asynchronous reset mid-transfer, then accept on the first edge.
    in_valid = 1'b1;
    in_data  = mk(16'h00E1);
    tick();
    in_data = mk(16'h00E2);
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready),  64'd1);
    chk("mid_rst_data",     out_data,       64'd0);
    #2 rst_n = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = mk(16'h00F1);
    in_ctrl   = 3'b100;
    tick();
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_data",  out_data,       mk(16'h00F1));
    in_valid = 1'b0;
    tick();
    chk("post_rst_drain", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_buffer
`default_nettype wire

// File: doc/pipe_buffer.md
PIPE_BUFFER -- requirements
Module: pipe_buffer

Interface
REQ-001 Parameter DATA_W, default 16: width of each data payload word.
REQ-002 Parameter NUM_WORDS, default 4: number of DATA_W payload words carried per beat (instruction, dOut, dIn, r0data equivalents).
REQ-003 Parameter CTRL_W, default 3: width of the control sideband (regWrite, mux3sel, r0Write equivalents).
REQ-004 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port in_valid, input, 1: upstream beat present.
REQ-007 Port in_ready, output, 1: stage can accept a beat this cycle.
REQ-008 Port in_data, input, DATA_W*NUM_WORDS: payload, word 0 in LSBs.
REQ-009 Port in_ctrl, input, CTRL_W: control sideband.
REQ-010 Port out_valid, output, 1: beat present at output.
REQ-011 Port out_ready, input, 1: downstream consumes beat this cycle.
REQ-012 Port out_data, output, DATA_W*NUM_WORDS: payload of head beat.
REQ-013 Port out_ctrl, output, CTRL_W: control of head beat, gated.
REQ-014 Port flush, input, 1: synchronous discard of all held and incoming beats.

Function
REQ-015 accept = in_valid & in_ready; take = out_valid & out_ready.
REQ-016 Storage: main register (drives outputs) plus one skid register; each holds data, ctrl and valid.
REQ-017 States: EMPTY (neither valid), ONE (main valid), TWO (main and skid valid).
REQ-018 in_ready SHALL be a registered signal, 1 in EMPTY and ONE, 0 in TWO; it does not depend combinationally on out_ready.
REQ-019 EMPTY: accept -> ONE, beat loads main.
REQ-020 ONE: accept & take -> ONE, new beat loads main; accept & !take -> TWO, new beat loads skid; !accept & take -> EMPTY; neither -> ONE, hold.
REQ-021 TWO: take -> ONE, skid moves to main; !take -> TWO, hold.
REQ-022 Latency: accepted beat appears at out_valid one cycle after the accepting edge; sustained throughput one beat per cycle while out_ready=1.
REQ-023 Ordering strictly FIFO; no beat duplicated or dropped except by flush.
REQ-024 out_valid = main valid; out_ctrl = main ctrl when out_valid, else all zero (bubble never asserts a write enable).
REQ-025 out_data holds last loaded main payload when out_valid=0; it is not cleared.
REQ-026 flush=1 at an edge: next state EMPTY, in_ready=1; any same-cycle accept is discarded; flush has priority over all transitions.
REQ-027 Data registers load only on accept or skid-to-main move; no update otherwise.

Reset
REQ-028 rst_n=0 forces immediately, independent of clk: state EMPTY, main/skid valid 0, in_ready 1, out_valid 0, out_ctrl 0, out_data 0, skid data/ctrl 0.
REQ-029 Reset asserted mid-transfer discards all held beats; after rst_n deasserts, first accept is allowed at the first clk edge.

Structure
REQ-030 Shared package pipe_pkg holds the state enum (EMPTY, ONE, TWO) and default width constants (DATA_W=16, CTRL_W=3, NUM_WORDS=4).
REQ-031 Single module, no sub-module; the skid path is inline.

Verification
REQ-032 Reset: rst_n=0 with in_valid=1, in_ctrl=3'b111 -> out_valid=0, out_ctrl=0, in_ready=1 asynchronously, before any clk edge.
REQ-033 Streaming: out_ready=1, beats with word0=0x0001..0x0008 on consecutive cycles -> same sequence at out_data, one cycle later, no gaps.
REQ-034 Backpressure: out_ready=0 after beat 0x00A1 held, send 0x00A2 -> in_ready drops to 0 next cycle; raise out_ready -> 0x00A1 then 0x00A2 delivered in order, in_ready returns to 1.
REQ-035 Bubble gating: ctrl=3'b101 beat consumed, in_valid=0 -> next cycle out_valid=0, out_ctrl=3'b000, out_data still shows that beat's payload.
REQ-036 Flush: state TWO (0x0B01, 0x0B02 held) with flush=1 and in_valid=1 (0x0B03) -> next cycle out_valid=0, in_ready=1; 0x0B01..0x0B03 never appear.
REQ-037 Parameters: DATA_W=32, NUM_WORDS=2, CTRL_W=5 instance passes REQ-033 with 64-bit payload 0xDEADBEEF_00000001 unchanged.
